// File: rtl/main_memory_responder_if.sv
// Block-transfer memory bus: the requester drives address/op/write data and
// the responder returns read data with a wait/complete handshake.
interface main_memory_responder_if #(
  parameter int ADDR_WIDTH       = 32,
  parameter int BLOCK_SIZE_BYTES = 32
);
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic                          mem_read;
  logic                          mem_write;
  logic [BLOCK_SIZE_BYTES*8-1:0] mem_wdata;
  logic [BLOCK_SIZE_BYTES*8-1:0] mem_rdata;
  logic                          mem_wait;

  modport master (
    output mem_addr, mem_read, mem_write, mem_wdata,
    input  mem_rdata, mem_wait
  );

  modport slave (
    input  mem_addr, mem_read, mem_write, mem_wdata,
    output mem_rdata, mem_wait
  );
endinterface

// File: rtl/main_memory_responder.sv
// Fixed-latency block memory model: accepts one block read or write in IDLE,
// waits LATENCY cycles, then signals completion for exactly one cycle.
module main_memory_responder #(
  parameter int ADDR_WIDTH       = 32,
  parameter int BLOCK_SIZE_BYTES = 32,
  parameter int DEPTH            = 256,
  parameter int LATENCY          = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  main_memory_responder_if.slave   mem,
  output logic                     err_sticky,
  output logic [15:0]              rd_count,
  output logic [15:0]              wr_count
);

  localparam int DATA_W      = BLOCK_SIZE_BYTES * 8;
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE_BYTES);
  localparam int IDX_BITS    = $clog2(DEPTH);
  localparam int HI_BIT      = OFFSET_BITS + IDX_BITS;
  localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                lat_write;
  logic                lat_oor;
  logic [IDX_BITS-1:0] lat_idx;
  logic [DATA_W-1:0]   lat_wdata;

  logic [DATA_W-1:0]   mem_array [DEPTH];

  logic [IDX_BITS-1:0] req_idx;
  logic                req_oor;
  logic                commit;
  logic                unused_addr_bits;

  assign req_idx          = mem.mem_addr[OFFSET_BITS +: IDX_BITS];
  // Any set bit above the index field makes the request out of range.
  assign req_oor          = |(mem.mem_addr >> HI_BIT);
  assign unused_addr_bits = ^mem.mem_addr;
  assign commit           = (state == BUSY) && (cnt == '0) && lat_write && !lat_oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_write     <= 1'b0;
      lat_oor       <= 1'b0;
      lat_idx       <= '0;
      lat_wdata     <= '0;
      mem.mem_wait  <= 1'b1;
      mem.mem_rdata <= '0;
      err_sticky    <= 1'b0;
      rd_count      <= '0;
      wr_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem.mem_read || mem.mem_write) begin
            lat_write <= mem.mem_write;
            lat_idx   <= req_idx;
            lat_oor   <= req_oor;
            lat_wdata <= mem.mem_wdata;
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= BUSY;
            if (req_oor || (mem.mem_read && mem.mem_write))
              err_sticky <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state        <= RESP;
            mem.mem_wait <= 1'b0;
            if (lat_write) begin
              wr_count <= wr_count + 16'd1;
            end else begin
              rd_count      <= rd_count + 16'd1;
              mem.mem_rdata <= lat_oor ? '0 : mem_array[lat_idx];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state        <= IDLE;
          mem.mem_wait <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          mem.mem_wait <= 1'b1;
        end
      endcase
    end
  end

  // Array has no reset; a reset in BUSY clears state so commit never fires.
  always_ff @(posedge clk) begin
    if (commit)
      mem_array[lat_idx] <= lat_wdata;
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: latency, read-back, back-to-back,
// out-of-range, simultaneous op, mid-request deassert and reset abort.
module tb_main_memory_responder;

  localparam int AW = 32;
  localparam int BS = 32;
  localparam int DW = BS * 8;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_sticky;
  logic [15:0] rd_count, wr_count;

  int total = 0;
  int bad   = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  int lat;
  logic [DW-1:0] rdat;

  localparam logic [DW-1:0] P_DEAD = {8{32'hDEADBEEF}};
  localparam logic [DW-1:0] P_CAFE = {8{32'hCAFEF00D}};
  localparam logic [DW-1:0] P_1234 = {8{32'h12345678}};
  localparam logic [DW-1:0] P_60   = {8{32'h0BADC0DE}};
  localparam logic [DW-1:0] P_NEW  = {8{32'hFEEDFACE}};
  localparam logic [DW-1:0] P_A5   = {32{8'hA5}};
  localparam logic [DW-1:0] P_OOR  = {8{32'h5A5A5A5A}};

  main_memory_responder_if #(.ADDR_WIDTH(AW), .BLOCK_SIZE_BYTES(BS)) mif ();

  main_memory_responder #(
    .ADDR_WIDTH(AW), .BLOCK_SIZE_BYTES(BS), .DEPTH(512), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem(mif.slave),
    .err_sticky(err_sticky), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns completion latency in cycles and
  // the data seen in the completion cycle, then leaves the bench at the next
  // IDLE negedge. hold=0 drops the request right after it is accepted.
  task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input bit hold,
                        output int latency, output logic [DW-1:0] data);
    latency = 99;
    data = 'x;
    mif.mem_read  = rd;
    mif.mem_write = wr;
    mif.mem_addr  = addr;
    mif.mem_wdata = wd;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) begin
        mif.mem_read  = 1'b0;
        mif.mem_write = 1'b0;
        mif.mem_addr  = '1;
        mif.mem_wdata = '0;
      end
      if (mif.mem_wait === 1'b0) begin
        latency = n;
        data = mif.mem_rdata;
        break;
      end
    end
    mif.mem_read  = 1'b0;
    mif.mem_write = 1'b0;
    mif.mem_addr  = '0;
    mif.mem_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    check("wait_one_cycle", {255'd0, mif.mem_wait}, {255'd0, 1'b1});
  endtask

  initial begin
    mif.mem_read  = 1'b0;
    mif.mem_write = 1'b0;
    mif.mem_addr  = '0;
    mif.mem_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_wait",  {255'd0, mif.mem_wait}, {255'd0, 1'b1});
    check("rst_rdata", mif.mem_rdata, '0);
    check("rst_err",   {255'd0, err_sticky}, '0);
    check("rst_rd",    {240'd0, rd_count}, '0);
    check("rst_wr",    {240'd0, wr_count}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read latency from a fresh block.
    do_req(1'b1, 1'b0, 32'h0000_0040, '0, 1'b1, lat, rdat); exp_rd++;
    check("rd_latency", DW'(lat), DW'(LAT + 1));
    check("rd_count1", {240'd0, rd_count}, DW'(exp_rd));

    // Write then read back via a different offset in the same block.
    do_req(1'b0, 1'b1, 32'h0000_0020, P_DEAD, 1'b1, lat, rdat); exp_wr++;
    check("wr_latency", DW'(lat), DW'(LAT + 1));
    check("wr_count1", {240'd0, wr_count}, DW'(exp_wr));
    do_req(1'b1, 1'b0, 32'h0000_003C, '0, 1'b1, lat, rdat); exp_rd++;
    check("readback", rdat, P_DEAD);
    check("rdata_hold_idle", mif.mem_rdata, P_DEAD);
    check("err_clean", {255'd0, err_sticky}, '0);

    // Back-to-back: write-back of 0x1000 then fill from 0x2000 (block 0x100).
    do_req(1'b0, 1'b1, 32'h0000_2000, P_1234, 1'b1, lat, rdat); exp_wr++;
    do_req(1'b0, 1'b1, 32'h0000_1000, P_CAFE, 1'b1, lat, rdat); exp_wr++;
    check("b2b_wr_latency", DW'(lat), DW'(LAT + 1));
    do_req(1'b1, 1'b0, 32'h0000_2000, '0, 1'b1, lat, rdat); exp_rd++;
    check("b2b_rd_latency", DW'(lat), DW'(LAT + 1));
    check("b2b_rd_data", rdat, P_1234);
    do_req(1'b1, 1'b0, 32'h0000_1000, '0, 1'b1, lat, rdat); exp_rd++;
    check("b2b_wr_data", rdat, P_CAFE);

    // Request dropped after acceptance still completes and commits.
    do_req(1'b0, 1'b1, 32'h0000_0060, P_60, 1'b0, lat, rdat); exp_wr++;
    check("drop_latency", DW'(lat), DW'(LAT + 1));
    do_req(1'b1, 1'b0, 32'h0000_0060, '0, 1'b1, lat, rdat); exp_rd++;
    check("drop_commit", rdat, P_60);

    // Out-of-range read.
    do_req(1'b1, 1'b0, 32'h0001_0000, '0, 1'b1, lat, rdat); exp_rd++;
    check("oor_latency", DW'(lat), DW'(LAT + 1));
    check("oor_rdata", rdat, '0);
    check("oor_err", {255'd0, err_sticky}, {255'd0, 1'b1});
    check("rd_count_pre", {240'd0, rd_count}, DW'(exp_rd));
    check("wr_count_pre", {240'd0, wr_count}, DW'(exp_wr));

    // Reset in BUSY cycle 2 of a write to 0x60 discards it.
    mif.mem_write = 1'b1;
    mif.mem_addr  = 32'h0000_0060;
    mif.mem_wdata = P_NEW;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    mif.mem_write = 1'b0;
    #1;
    check("abort_wait", {255'd0, mif.mem_wait}, {255'd0, 1'b1});
    check("abort_rd", {240'd0, rd_count}, '0);
    check("abort_wr", {240'd0, wr_count}, '0);
    check("abort_err", {255'd0, err_sticky}, '0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    @(negedge clk);
    do_req(1'b1, 1'b0, 32'h0000_0060, '0, 1'b1, lat, rdat); exp_rd++;
    check("abort_old_data", rdat, P_60);

    // Simultaneous read and write resolves to a write and flags an error.
    do_req(1'b1, 1'b1, 32'h0000_0040, P_A5, 1'b1, lat, rdat); exp_wr++;
    check("both_err", {255'd0, err_sticky}, {255'd0, 1'b1});
    check("both_wr", {240'd0, wr_count}, DW'(exp_wr));
    check("both_rd", {240'd0, rd_count}, DW'(exp_rd));
    do_req(1'b1, 1'b0, 32'h0000_0040, '0, 1'b1, lat, rdat); exp_rd++;
    check("both_data", rdat, P_A5);

    // Out-of-range write aliasing block 2 must leave the array untouched.
    do_req(1'b0, 1'b1, 32'h0001_0040, P_OOR, 1'b1, lat, rdat); exp_wr++;
    check("oor_wr_latency", DW'(lat), DW'(LAT + 1));
    do_req(1'b1, 1'b0, 32'h0000_0040, '0, 1'b1, lat, rdat); exp_rd++;
    check("oor_wr_nochange", rdat, P_A5);
    check("final_rd", {240'd0, rd_count}, DW'(exp_rd));
    check("final_wr", {240'd0, wr_count}, DW'(exp_wr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 The block SHALL expose parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 The block SHALL expose parameter BLOCK_SIZE_BYTES, default 32, transfer size per request in bytes.
REQ-003 The block SHALL expose parameter DEPTH, default 256, number of blocks stored (power of two).
REQ-004 The block SHALL expose parameter LATENCY, default 3, number of BUSY cycles per request (>=1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 mem_addr  input  ADDR_WIDTH  byte address of the requested block.
REQ-008 mem_read  input  1  block read request, held high until the completion cycle.
REQ-009 mem_write  input  1  block write request, held high until the completion cycle.
REQ-010 mem_wdata  input  BLOCK_SIZE_BYTES*8  write block data.
REQ-011 mem_rdata  output  BLOCK_SIZE_BYTES*8  read block data; valid only in the completion cycle.
REQ-012 mem_wait  output  1  high = not complete; low for exactly one cycle = request complete.
REQ-013 err_sticky  output  1  set on any out-of-range access; cleared only by reset.
REQ-014 rd_count, wr_count  output  16 each  completed read and write counts; wrap at 16'hFFFF -> 0.

Function
REQ-015 The block SHALL store DEPTH blocks of BLOCK_SIZE_BYTES*8 bits, indexed by mem_addr[OFFSET_BITS +: log2(DEPTH)], where OFFSET_BITS = log2(BLOCK_SIZE_BYTES); the offset bits are ignored.
REQ-016 An address SHALL be out of range when any mem_addr bit at or above OFFSET_BITS+log2(DEPTH) is 1.
REQ-017 The state machine SHALL have three states: IDLE, BUSY and RESP.
REQ-018 IDLE: mem_wait=1; on a clock edge with mem_read or mem_write high, the block SHALL latch addr, op and wdata, load the counter with LATENCY-1 and go to BUSY.
REQ-019 When mem_read and mem_write are both high in IDLE, the op SHALL be a write; the block SHALL also set err_sticky.
REQ-020 BUSY: mem_wait=1; the counter SHALL decrement each cycle; with the counter at 0 the block SHALL go to RESP on the next edge.
REQ-021 On the BUSY->RESP edge the block SHALL commit a latched in-range write to the array and register the array word into mem_rdata for a read.
REQ-022 RESP: mem_wait=0 (registered output) for exactly one cycle, then unconditionally IDLE.
REQ-023 Latency SHALL be fixed: request first high in cycle 0 gives mem_wait=0 in cycle LATENCY+1; a new request is accepted no earlier than cycle LATENCY+2.
REQ-024 mem_addr, mem_wdata and the request lines SHALL be ignored outside IDLE; deassertion mid-request SHALL NOT abort the request, and a write SHALL still be committed.
REQ-025 Out-of-range read: mem_rdata=0. Out-of-range write: array unchanged. Both SHALL complete with normal timing and set err_sticky.
REQ-026 rd_count/wr_count SHALL increment on the RESP cycle of each completed read/write, in range or not.
REQ-027 In IDLE and BUSY, mem_rdata SHALL hold its last value.
REQ-028 A write followed by a read to the same block SHALL return the newly written data.

Reset
REQ-029 While rst_n=0: state=IDLE, mem_wait=1, mem_rdata=0, err_sticky=0, rd_count=0, wr_count=0, counter=0.
REQ-030 Array contents SHALL NOT be reset.
REQ-031 Reset asserted in BUSY or RESP SHALL discard the request; an uncommitted write SHALL NOT reach the array.

Verification
REQ-032 Read latency: LATENCY=3, mem_read=1, addr 0x0000_0040 from cycle 0 -> mem_wait=0 only in cycle 4; rd_count=1.
REQ-033 Write/read-back: write addr 0x0000_0020, data {8{32'hDEADBEEF}}, then read 0x0000_003C -> same data returned; wr_count=1, rd_count=1.
REQ-034 Back-to-back (write-back then fill): write 0x0000_1000, then read 0x0000_2000 issued the cycle after RESP -> each completes 4 cycles after its start; the second returns the array contents of block 0x100.
REQ-035 Out of range: DEPTH=256, read 0x0001_0000 -> mem_rdata=0, err_sticky=1, timing unchanged.
REQ-036 Simultaneous read and write to 0x40 with data 0xA5 pattern -> treated as a write; err_sticky=1; a read of 0x40 returns the 0xA5 pattern.
REQ-037 Reset mid-write: rst_n=0 in BUSY cycle 2 -> mem_wait=1, counts 0; a subsequent read of that block shows the old data.
